// File: rtl/unsigned_divider_pkg.sv
// unsigned_divider_pkg: shared state encoding, widths and status bit positions
package unsigned_divider_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int OPW = 4;
  localparam int CNTW = $clog2(OPW);
  localparam logic [7:0] UIO_OE_MASK = 8'h07;
  localparam int BUSY_BIT = 0;
  localparam int VALID_BIT = 1;
  localparam int DBZ_BIT = 2;
endpackage

// File: rtl/unsigned_divider_div_step.sv
// div_step: one combinational restoring-division step
module div_step
  import unsigned_divider_pkg::*;
(
  input  logic [OPW:0]   r_i,
  input  logic [OPW-1:0] q_i,
  input  logic [OPW-1:0] d_i,
  output logic [OPW:0]   r_o,
  output logic [OPW-1:0] q_o
);
  logic [OPW:0] sh;
  logic ge;
  logic unused_r;
  assign unused_r = r_i[OPW];
  // shift in the next dividend bit, subtract when the divisor fits
  always_comb begin
    sh = {r_i[OPW-1:0], q_i[OPW-1]};
    ge = sh >= {1'b0, d_i};
    r_o = ge ? sh - {1'b0, d_i} : sh;
    q_o = {q_i[OPW-2:0], ge};
  end
endmodule

// File: rtl/unsigned_divider.sv
// unsigned_divider: continuously sampling 4-bit sequential restoring divider
module unsigned_divider
  import unsigned_divider_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  state_t state_q;
  logic [CNTW-1:0] cnt_q;
  logic [OPW-1:0] q_q, d_q, q_d;
  logic [OPW:0] r_q, r_d;
  logic [7:0] out_q;
  logic dbz_q, valid_q;
  logic unused;
  div_step u_step (.r_i(r_q), .q_i(q_q), .d_i(d_q), .r_o(r_d), .q_o(q_d));
  // sample in IDLE, step through CALC, publish in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      q_q <= '0;
      d_q <= '0;
      r_q <= '0;
      out_q <= '0;
      dbz_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= state_q == DONE;
      case (state_q)
        IDLE: begin
          q_q <= ui_in[OPW-1:0];
          d_q <= ui_in[2*OPW-1:OPW];
          r_q <= '0;
          cnt_q <= '0;
          state_q <= CALC;
        end
        CALC: begin
          r_q <= r_d;
          q_q <= q_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNTW'(OPW - 1)) state_q <= DONE;
        end
        DONE: begin
          out_q <= {r_q[OPW-1:0], q_q};
          dbz_q <= d_q == '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // status pins
  always_comb begin
    uio_out = '0;
    uio_out[BUSY_BIT] = state_q != IDLE;
    uio_out[VALID_BIT] = valid_q;
    uio_out[DBZ_BIT] = dbz_q;
  end
  assign uo_out = out_q;
  assign uio_oe = UIO_OE_MASK;
  assign unused = &{1'b0, ena, uio_in, r_q[OPW]};
endmodule

// File: tb/tb_unsigned_divider.sv
// tb_unsigned_divider: scoreboard bench for the sequential divider
module tb_unsigned_divider;
  logic clk = 0, rst = 1, ena = 1;
  logic [7:0] ui_in = 0, uio_in = 0;
  logic [7:0] uo_out, uio_out, uio_oe;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {logic [7:0] uo; logic dbz; int cyc;} exp_t;
  exp_t sb[$];
  unsigned_divider dut (.clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (uio_out[1]) begin
      if (sb.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("uo_out", uo_out, e.uo);
        chk("div_by_zero", uio_out[2], e.dbz);
        chk("latency", cyc, e.cyc);
        chk("busy_at_valid", uio_out[0], 0);
      end
    end
  end
  task automatic issue(input logic [7:0] v, input logic [7:0] uo, input logic dbz, input bit junk);
    int n = 0;
    while (uio_out[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (uio_out[0]) chk("idle_timeout", 1, 0);
    ui_in = v;
    sb.push_back('{uo: uo, dbz: dbz, cyc: cyc + 6});
    @(posedge clk);
    if (junk) begin
      for (int k = 0; k < 2; k++) begin
        repeat (2) @(negedge clk);
        ui_in = 8'($urandom);
      end
    end else @(negedge clk);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_uo_out", uo_out, 8'h00);
    chk("rst_uio_out", uio_out, 8'h00);
    chk("rst_uio_oe", uio_oe, 8'h07);
    rst = 0;
    issue(8'h5A, 8'h02, 0, 0);
    issue(8'h3F, 8'h05, 0, 1);
    issue(8'h28, 8'h04, 0, 1);
    issue(8'h4D, 8'h13, 0, 0);
    issue(8'h93, 8'h30, 0, 0);
    issue(8'h07, 8'h7F, 1, 0);
    issue(8'h19, 8'h09, 0, 0);
    while (uio_out[0]) @(negedge clk);
    ui_in = 8'h4D;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("abort_uo_out", uo_out, 8'h00);
    chk("abort_uio_out", uio_out, 8'h00);
    @(negedge clk);
    chk("abort_hold_uio_out", uio_out, 8'h00);
    rst = 0;
    ui_in = 8'h28;
    sb.push_back('{uo: 8'h04, dbz: 0, cyc: cyc + 6});
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      logic [3:0] a, d, q, r;
      v = 8'(i);
      a = v[3:0];
      d = v[7:4];
      q = (d == 0) ? 4'hF : a / d;
      r = (d == 0) ? a : a % d;
      issue(v, {r, q}, d == 0, 0);
    end
    for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
